// File: rtl/commit_trace_buffer.sv
// Retirement monitor: classifies each committed instruction into a trace record,
// queues records in a small FIFO with a valid/ready drain port, and tracks cycle/instruction counts.
module commit_trace_buffer #(
   parameter int DEPTH       = 16,
   parameter int CYCLE_LIMIT = 100000,
   parameter int INUM_W      = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [15:0]       commit_pc,
   input  logic              commit_reg_write,
   input  logic [3:0]        commit_wreg,
   input  logic [15:0]       commit_wdata,
   input  logic              commit_mem_read,
   input  logic              commit_mem_write,
   input  logic [15:0]       commit_mem_addr,
   input  logic [15:0]       commit_mem_data,
   input  logic              commit_halt,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [2:0]        out_type,
   output logic [INUM_W-1:0] out_inum,
   output logic [15:0]       out_pc,
   output logic [3:0]        out_reg,
   output logic [15:0]       out_value,
   output logic [15:0]       out_addr,
   output logic              halted,
   output logic              timeout,
   output logic              overflow,
   output logic              done,
   output logic [31:0]       cycle_count,
   output logic [INUM_W-1:0] inst_count,
   output logic [7:0]        drop_count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [1:0] RUN     = 2'd0;
   localparam logic [1:0] HALTED  = 2'd1;
   localparam logic [1:0] TIMEOUT = 2'd2;

   localparam logic [2:0] T_OTHER = 3'd0;
   localparam logic [2:0] T_REG   = 3'd1;
   localparam logic [2:0] T_LD    = 3'd2;
   localparam logic [2:0] T_ST    = 3'd3;
   localparam logic [2:0] T_HALT  = 3'd4;

   logic [1:0]        state;
   logic [AW-1:0]     rdPtr, wrPtr;
   logic [AW:0]       count;

   logic [2:0]        typeMem  [DEPTH];
   logic [INUM_W-1:0] inumMem  [DEPTH];
   logic [15:0]       pcMem    [DEPTH];
   logic [3:0]        regMem   [DEPTH];
   logic [15:0]       valueMem [DEPTH];
   logic [15:0]       addrMem  [DEPTH];

   logic [2:0]        recType;
   logic [3:0]        recReg;
   logic [15:0]       recValue, recAddr;
   logic              gen, push, pop, full;

   always_comb begin
      recType  = T_OTHER;
      recReg   = '0;
      recValue = '0;
      recAddr  = '0;
      if (commit_reg_write && commit_mem_read) begin
         recType  = T_LD;
         recReg   = commit_wreg;
         recValue = commit_wdata;
         recAddr  = commit_mem_addr;
      end else if (commit_reg_write) begin
         recType  = T_REG;
         recReg   = commit_wreg;
         recValue = commit_wdata;
      end else if (commit_halt) begin
         recType  = T_HALT;
      end else if (commit_mem_write) begin
         recType  = T_ST;
         recValue = commit_mem_data;
         recAddr  = commit_mem_addr;
      end
   end

   assign full      = (count == (AW+1)'(DEPTH));
   assign out_valid = (count != '0);
   assign gen       = (state == RUN) && (cycle_count != 32'(CYCLE_LIMIT));
   assign pop       = out_valid && out_ready;
   // A full FIFO still accepts a record when the head leaves on the same edge.
   assign push      = gen && (!full || pop);

   assign out_type  = out_valid ? typeMem[rdPtr]  : '0;
   assign out_inum  = out_valid ? inumMem[rdPtr]  : '0;
   assign out_pc    = out_valid ? pcMem[rdPtr]    : '0;
   assign out_reg   = out_valid ? regMem[rdPtr]   : '0;
   assign out_value = out_valid ? valueMem[rdPtr] : '0;
   assign out_addr  = out_valid ? addrMem[rdPtr]  : '0;

   assign halted  = (state == HALTED);
   assign timeout = (state == TIMEOUT);
   assign done    = (halted || timeout) && !out_valid;

   always_ff @(posedge clk) begin
      if (push) begin
         typeMem[wrPtr]  <= recType;
         inumMem[wrPtr]  <= inst_count;
         pcMem[wrPtr]    <= commit_pc;
         regMem[wrPtr]   <= recReg;
         valueMem[wrPtr] <= recValue;
         addrMem[wrPtr]  <= recAddr;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= RUN;
         rdPtr       <= '0;
         wrPtr       <= '0;
         count       <= '0;
         cycle_count <= '0;
         inst_count  <= '0;
         drop_count  <= '0;
         overflow    <= 1'b0;
      end else begin
         if (push) wrPtr <= wrPtr + AW'(1);
         if (pop)  rdPtr <= rdPtr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase

         if (state == RUN) begin
            if (!gen) begin
               state <= TIMEOUT;
            end else begin
               cycle_count <= cycle_count + 32'd1;
               inst_count  <= inst_count + INUM_W'(1);
               if (!push) begin
                  overflow <= 1'b1;
                  if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
               end
               if (recType == T_HALT) state <= HALTED;
            end
         end
      end
   end

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed bench for commit_trace_buffer: a queue scoreboard predicts every trace record
// and the counters/flags, and compares them as records leave the drain port.
module tb_commit_trace_buffer;

   localparam int DEPTH = 4;
   localparam int LIMIT = 20;
   localparam int IW    = 16;

   typedef struct packed {
      logic [2:0]    typ;
      logic [IW-1:0] inum;
      logic [15:0]   pc;
      logic [3:0]    rg;
      logic [15:0]   value;
      logic [15:0]   addr;
   } rec_t;

   logic clk = 1'b0;
   logic rst_n;
   logic [15:0] pc, wdata, maddr, mdata;
   logic [3:0] wreg;
   logic rw, mr, mw, hlt, outReady;
   logic out_valid, halted, timeout, overflow, done;
   logic [2:0] out_type;
   logic [IW-1:0] out_inum, inst_count;
   logic [15:0] out_pc, out_value, out_addr;
   logic [3:0] out_reg;
   logic [31:0] cycle_count;
   logic [7:0] drop_count;

   int checks = 0;
   int errors = 0;

   rec_t sb[$];
   int mState;               // 0 run, 1 halted, 2 timeout
   int mCycle, mInst, mDrop;
   bit mOvf;

   commit_trace_buffer #(.DEPTH(DEPTH), .CYCLE_LIMIT(LIMIT), .INUM_W(IW)) dut (
      .clk(clk), .rst_n(rst_n),
      .commit_pc(pc), .commit_reg_write(rw), .commit_wreg(wreg), .commit_wdata(wdata),
      .commit_mem_read(mr), .commit_mem_write(mw), .commit_mem_addr(maddr),
      .commit_mem_data(mdata), .commit_halt(hlt),
      .out_valid(out_valid), .out_ready(outReady), .out_type(out_type), .out_inum(out_inum),
      .out_pc(out_pc), .out_reg(out_reg), .out_value(out_value), .out_addr(out_addr),
      .halted(halted), .timeout(timeout), .overflow(overflow), .done(done),
      .cycle_count(cycle_count), .inst_count(inst_count), .drop_count(drop_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic rec_t expRec();
      rec_t r;
      r = '0;
      r.pc   = pc;
      r.inum = IW'(mInst);
      if (rw && mr) begin
         r.typ = 3'd2; r.rg = wreg; r.value = wdata; r.addr = maddr;
      end else if (rw) begin
         r.typ = 3'd1; r.rg = wreg; r.value = wdata;
      end else if (hlt) begin
         r.typ = 3'd4;
      end else if (mw) begin
         r.typ = 3'd3; r.value = mdata; r.addr = maddr;
      end
      return r;
   endfunction

   task automatic drv(input bit irw, input bit imr, input bit imw, input bit ih,
                      input logic [15:0] ipc, input logic [3:0] ireg,
                      input logic [15:0] iwd, input logic [15:0] ima, input logic [15:0] imd);
      rw = irw; mr = imr; mw = imw; hlt = ih;
      pc = ipc; wreg = ireg; wdata = iwd; maddr = ima; mdata = imd;
   endtask

   // One clock: compare/pop a departing head, predict the edge, then check valid after it.
   task automatic tick();
      bit popNow;
      rec_t e, r;
      popNow = 0;
      if (rst_n) begin
         if (out_valid && outReady) begin
            popNow = 1;
            if (sb.size() == 0) chk("unexpected_record", 80'(out_inum), 80'hFFFF_FFFF);
            else begin
               e = sb.pop_front();
               chk("record", 80'({out_type, out_inum, out_pc, out_reg, out_value, out_addr}), 80'(e));
            end
         end
         if (mState == 0) begin
            if (mCycle == LIMIT) mState = 2;
            else begin
               mCycle++;
               r = expRec();
               if (sb.size() < DEPTH) sb.push_back(r);
               else begin
                  mOvf = 1;
                  if (mDrop < 255) mDrop++;
               end
               mInst = (mInst + 1) % (1 << IW);
               if (r.typ == 3'd4) mState = 1;
            end
         end
      end else begin
         sb.delete();
         mState = 0; mCycle = 0; mInst = 0; mDrop = 0; mOvf = 0;
      end
      @(posedge clk);
      #1;
      chk("out_valid", 80'(out_valid), 80'(sb.size() != 0));
   endtask

   task automatic chkCounters(input string tag);
      chk({tag, "_cycle"}, 80'(cycle_count), 80'(mCycle));
      chk({tag, "_inst"}, 80'(inst_count), 80'(mInst));
      chk({tag, "_drop"}, 80'(drop_count), 80'(mDrop));
      chk({tag, "_flags"}, 80'({halted, timeout, overflow}), 80'({mState == 1, mState == 2, mOvf}));
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 16 && sb.size() != 0; i++) tick();
      chk({tag, "_drained"}, 80'(sb.size()), 80'(0));
      tick();
      chk({tag, "_done"}, 80'(done), 80'(1));
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      outReady = 1'b1;
      drv(0, 0, 0, 0, 16'h0, 4'h0, 16'h0, 16'h0, 16'h0);

      // Reset state and first REG record
      doReset();
      chkCounters("reset");
      chk("reset_outs", 80'({done, out_type, out_inum, out_pc, out_value}), 80'(0));
      drv(1, 0, 0, 0, 16'h0000, 4'd3, 16'h0005, 16'h0, 16'h0);
      tick();
      chk("first_cycle", 80'(cycle_count), 80'(1));
      chk("first_inst", 80'(inst_count), 80'(1));
      chk("first_head", 80'({out_type, out_inum, out_pc, out_reg, out_value, out_addr}),
          80'({3'd1, 16'd0, 16'h0000, 4'd3, 16'h0005, 16'h0000}));

      // LD, ST, NOP, REG+halt, HALT, then ignored inputs
      doReset();
      drv(1, 1, 0, 0, 16'h0001, 4'd2, 16'hBEEF, 16'h0010, 16'h0);   tick();
      drv(0, 0, 1, 0, 16'h0002, 4'd7, 16'h1111, 16'h0012, 16'h1234); tick();
      drv(0, 0, 0, 0, 16'h0003, 4'd0, 16'h0, 16'h0, 16'h0);         tick();
      drv(1, 0, 0, 1, 16'h0004, 4'd5, 16'h0007, 16'h0, 16'h0);      tick();
      drv(0, 0, 0, 1, 16'h0005, 4'd9, 16'h2222, 16'h0033, 16'h4444); tick();
      chkCounters("halt");
      drv(1, 0, 0, 0, 16'h0006, 4'd1, 16'h9999, 16'h0, 16'h0);
      drain("halt");
      chkCounters("halt_after");
      chk("halt_cycle5", 80'(cycle_count), 80'(5));

      // Overflow with stalled consumer, then push+pop on full, then run into the watchdog
      doReset();
      outReady = 1'b0;
      for (int i = 0; i < 6; i++) begin
         drv(0, 0, 0, 0, 16'(16'h0100 + i), 4'd0, 16'h0, 16'h0, 16'h0);
         tick();
      end
      chkCounters("ovf");
      chk("ovf_head_inum", 80'(out_inum), 80'(0));
      outReady = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drv(1, 0, 0, 0, 16'(16'h0200 + i), 4'(i), 16'(16'hA000 + i), 16'h0, 16'h0);
         tick();
      end
      chkCounters("fullpp");
      for (int i = 0; i < 12; i++) begin
         drv(0, 0, 1, 0, 16'(16'h0300 + i), 4'd0, 16'h0, 16'(16'h0040 + i), 16'(16'h5000 + i));
         tick();
      end
      tick();
      chkCounters("timeout");
      chk("timeout_cycle20", 80'(cycle_count), 80'(20));
      drain("timeout");
      chk("no_21st", 80'(inst_count), 80'(20));

      // Reset in the middle of a drain
      doReset();
      outReady = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drv(1, 0, 0, 0, 16'(16'h0400 + i), 4'd4, 16'(16'hC000 + i), 16'h0, 16'h0);
         tick();
      end
      outReady = 1'b1;
      rst_n = 1'b0;
      tick();
      chkCounters("midreset");
      chk("midreset_done", 80'(done), 80'(0));
      rst_n = 1'b1;
      drv(0, 0, 0, 1, 16'h0777, 4'd0, 16'h0, 16'h0, 16'h0);
      tick();
      chk("post_reset_head", 80'({out_type, out_inum, out_pc}), 80'({3'd4, 16'd0, 16'h0777}));
      drain("post_reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "bench time limit expired");
   end

endmodule
